frame_bank_scheduler: RTL and testbench

Triple-buffer bank scheduler for the SDRAM frame store between the CMOS capture path (writer) and the VGA scan-out path (reader). It assigns SDRAM banks 0–2 to three roles: write, read and latest-complete. On frame boundaries it rotates those roles so that the writer and the reader never share a bank and the reader always starts on the newest complete frame. It drives the bank-select and address-reload (`load`) pulses of the SDRAM write and read FIFO controllers.

---
 rtl/frame_bank_scheduler_if.sv | 22 ++
 rtl/frame_bank_scheduler.sv | 107 ++++++++++
 tb/tb_frame_bank_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/frame_bank_scheduler_if.sv
// frame_bank_scheduler_if: frame boundary pulses in, bank selects, load pulses and stats out.
interface frame_bank_scheduler_if;
  logic       i_wr_frame_start;
  logic       i_wr_frame_done;
  logic       i_rd_frame_start;
  logic       i_rd_frame_done;
  logic [1:0] o_wr_bank;
  logic [1:0] o_rd_bank;
  logic       o_wr_load;
  logic       o_rd_load;
  logic       o_frame_ready;
  logic [7:0] o_drop_cnt;
  logic [7:0] o_repeat_cnt;
  modport master(
    output i_wr_frame_start, i_wr_frame_done, i_rd_frame_start, i_rd_frame_done,
    input  o_wr_bank, o_rd_bank, o_wr_load, o_rd_load, o_frame_ready, o_drop_cnt, o_repeat_cnt
  );
  modport slave(
    input  i_wr_frame_start, i_wr_frame_done, i_rd_frame_start, i_rd_frame_done,
    output o_wr_bank, o_rd_bank, o_wr_load, o_rd_load, o_frame_ready, o_drop_cnt, o_repeat_cnt
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler: triple-buffer bank rotation between SDRAM writer and reader.
// FRAME_BANK_STATS_EN builds the drop/repeat counters; otherwise both read as zero.
module frame_bank_scheduler #(
  parameter int LOAD_LEN = 2
) (
  input logic clk,
  input logic rst_n,
  frame_bank_scheduler_if.slave bus
);
  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_ACTIVE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_ACTIVE} r_state_t;
  localparam logic [3:0] LOAD_CNT = 4'(LOAD_LEN - 1);
  w_state_t   r_wr_st;
  r_state_t   r_rd_st;
  logic [3:0] r_wr_cnt, r_rd_cnt;
  logic [1:0] r_wr_bank, r_rd_bank, r_latest;
  logic       r_fresh, r_wr_load, r_rd_load, r_ready;
  logic       w_commit, w_swap, w_take, w_nxt_fresh;
  logic [1:0] w_nxt_latest, w_rd_next, w_latest_next, w_wr_next;
  // Swap sees the post-commit latest, so a same-cycle commit is handed straight to the reader.
  assign w_commit      = r_wr_st == W_ACTIVE && bus.i_wr_frame_done;
  assign w_swap        = bus.i_rd_frame_start && r_rd_st != R_LOAD;
  assign w_nxt_fresh   = w_commit | r_fresh;
  assign w_nxt_latest  = w_commit ? r_wr_bank : r_latest;
  assign w_take        = w_swap && w_nxt_fresh;
  assign w_rd_next     = w_take ? w_nxt_latest : r_rd_bank;
  assign w_latest_next = w_take ? r_rd_bank : w_nxt_latest;
  assign w_wr_next     = w_commit ? 2'd3 - w_rd_next - w_latest_next : r_wr_bank;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_st   <= W_IDLE;
      r_rd_st   <= R_IDLE;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_wr_bank <= 2'd0;
      r_rd_bank <= 2'd1;
      r_latest  <= 2'd2;
      r_fresh   <= 1'b0;
      r_wr_load <= 1'b0;
      r_rd_load <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_wr_bank <= w_wr_next;
      r_rd_bank <= w_rd_next;
      r_latest  <= w_latest_next;
      r_fresh   <= w_nxt_fresh & ~w_take;
      if (w_commit) r_ready <= 1'b1;
      case (r_wr_st)
        W_IDLE: if (bus.i_wr_frame_start) begin
          r_wr_st   <= W_LOAD;
          r_wr_load <= 1'b1;
          r_wr_cnt  <= LOAD_CNT;
        end
        W_LOAD: if (r_wr_cnt == 4'd0) begin
          r_wr_st   <= W_ACTIVE;
          r_wr_load <= 1'b0;
        end else r_wr_cnt <= r_wr_cnt - 4'd1;
        W_ACTIVE: if (bus.i_wr_frame_done) r_wr_st <= W_IDLE;
          else if (bus.i_wr_frame_start) begin
            r_wr_st   <= W_LOAD;
            r_wr_load <= 1'b1;
            r_wr_cnt  <= LOAD_CNT;
          end
        default: r_wr_st <= W_IDLE;
      endcase
      case (r_rd_st)
        R_IDLE: if (bus.i_rd_frame_start) begin
          r_rd_st   <= R_LOAD;
          r_rd_load <= 1'b1;
          r_rd_cnt  <= LOAD_CNT;
        end
        R_LOAD: if (r_rd_cnt == 4'd0) begin
          r_rd_st   <= R_ACTIVE;
          r_rd_load <= 1'b0;
        end else r_rd_cnt <= r_rd_cnt - 4'd1;
        R_ACTIVE: if (bus.i_rd_frame_start) begin
            r_rd_st   <= R_LOAD;
            r_rd_load <= 1'b1;
            r_rd_cnt  <= LOAD_CNT;
          end else if (bus.i_rd_frame_done) r_rd_st <= R_IDLE;
        default: r_rd_st <= R_IDLE;
      endcase
    end
  end
  assign bus.o_wr_bank     = r_wr_bank;
  assign bus.o_rd_bank     = r_rd_bank;
  assign bus.o_wr_load     = r_wr_load;
  assign bus.o_rd_load     = r_rd_load;
  assign bus.o_frame_ready = r_ready;
`ifdef FRAME_BANK_STATS_EN
  logic [7:0] r_drop, r_repeat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop   <= '0;
      r_repeat <= '0;
    end else begin
      if (w_commit && r_fresh && r_drop != 8'hff) r_drop <= r_drop + 8'd1;
      if (w_swap && !w_nxt_fresh && r_repeat != 8'hff) r_repeat <= r_repeat + 8'd1;
    end
  end
  assign bus.o_drop_cnt   = r_drop;
  assign bus.o_repeat_cnt = r_repeat;
`else
  assign bus.o_drop_cnt   = '0;
  assign bus.o_repeat_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb_frame_bank_scheduler: role-level model of the triple buffer checked every cycle,
// plus directed scenarios with literal expectations and a random pulse soak.
module tb_frame_bank_scheduler;
  localparam int LOAD_LEN = 2;
`ifdef FRAME_BANK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  frame_bank_scheduler_if bus();
  frame_bank_scheduler #(.LOAD_LEN(LOAD_LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Model: banks as roles, phases as idle(0)/load(1)/active(2) with remaining load cycles.
  int m_wr, m_rd, m_lat, m_fresh, m_ready, m_drop, m_rep, m_wph, m_wrem, m_rph, m_rrem;
  task automatic model_reset();
    m_wr = 0; m_rd = 1; m_lat = 2; m_fresh = 0; m_ready = 0; m_drop = 0; m_rep = 0;
    m_wph = 0; m_wrem = 0; m_rph = 0; m_rrem = 0;
  endtask
  initial model_reset();
  always @(posedge clk) begin
    bit ws, wd, rs, rd, commit, swap;
    int t;
    ws = bus.i_wr_frame_start; wd = bus.i_wr_frame_done;
    rs = bus.i_rd_frame_start; rd = bus.i_rd_frame_done;
    if (!rst_n) model_reset();
    else begin
      commit = (m_wph == 2) && wd;
      swap = rs && (m_rph != 1);
      if (m_wph == 1) begin
        m_wrem--;
        if (m_wrem == 0) m_wph = 2;
      end else if (m_wph == 0 && ws) begin
        m_wph = 1; m_wrem = LOAD_LEN;
      end else if (m_wph == 2) begin
        if (wd) m_wph = 0;
        else if (ws) begin m_wph = 1; m_wrem = LOAD_LEN; end
      end
      if (m_rph == 1) begin
        m_rrem--;
        if (m_rrem == 0) m_rph = 2;
      end else if (rs) begin
        m_rph = 1; m_rrem = LOAD_LEN;
      end else if (m_rph == 2 && rd) m_rph = 0;
      if (commit) begin
        if (m_fresh != 0 && m_drop < 255) m_drop++;
        m_lat = m_wr; m_fresh = 1; m_ready = 1;
      end
      if (swap) begin
        if (m_fresh != 0) begin
          t = m_rd; m_rd = m_lat; m_lat = t; m_fresh = 0;
        end else if (m_rep < 255) m_rep++;
      end
      if (commit)
        for (int b = 0; b < 3; b++) if (b != m_rd && b != m_lat) m_wr = b;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst_n && cmp_en) begin
    chk("wr_bank", bus.o_wr_bank, m_wr);
    chk("rd_bank", bus.o_rd_bank, m_rd);
    chk("wr_load", bus.o_wr_load, int'(m_wph == 1));
    chk("rd_load", bus.o_rd_load, int'(m_rph == 1));
    chk("frame_ready", bus.o_frame_ready, m_ready);
    chk("drop_cnt", bus.o_drop_cnt, STATS ? m_drop : 0);
    chk("repeat_cnt", bus.o_repeat_cnt, STATS ? m_rep : 0);
    chk("excl_wr_rd", int'(bus.o_wr_bank != bus.o_rd_bank), 1);
    chk("no_bank3", int'(bus.o_wr_bank != 2'd3 && bus.o_rd_bank != 2'd3), 1);
  end
  task automatic set_in(input bit wfs, input bit wfd, input bit rfs, input bit rfd);
    bus.i_wr_frame_start = wfs; bus.i_wr_frame_done = wfd;
    bus.i_rd_frame_start = rfs; bus.i_rd_frame_done = rfd;
  endtask
  task automatic pulse(input bit wfs, input bit wfd, input bit rfs, input bit rfd);
    set_in(wfs, wfd, rfs, rfd);
    @(negedge clk);
    set_in(0, 0, 0, 0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    set_in(0, 0, 0, 0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask
  task automatic write_frame();
    pulse(1, 0, 0, 0);
    idle(3);
    pulse(0, 1, 0, 0);
  endtask
  initial begin
    set_in(0, 0, 0, 0);
    do_reset();
    cmp_en = 1'b1;
    idle(10);
    chk("lit_rst_wr", bus.o_wr_bank, 0);
    chk("lit_rst_rd", bus.o_rd_bank, 1);
    chk("lit_rst_ready", bus.o_frame_ready, 0);
    chk("lit_rst_loads", {bus.o_wr_load, bus.o_rd_load}, 0);
    pulse(1, 0, 0, 0);
    chk("lit_wload_c1", bus.o_wr_load, 1);
    idle(1);
    chk("lit_wload_c2", bus.o_wr_load, 1);
    idle(1);
    chk("lit_wload_c3", bus.o_wr_load, 0);
    pulse(0, 1, 0, 0);
    chk("lit_commit_ready", bus.o_frame_ready, 1);
    chk("lit_commit_wr", bus.o_wr_bank, 2);
    pulse(0, 0, 1, 0);
    chk("lit_swap_rd", bus.o_rd_bank, 0);
    chk("lit_rload_c1", bus.o_rd_load, 1);
    idle(1);
    chk("lit_rload_c2", bus.o_rd_load, 1);
    idle(1);
    chk("lit_rload_c3", bus.o_rd_load, 0);
    chk("lit_swap_wr", bus.o_wr_bank, 2);
    pulse(0, 0, 0, 1);
    write_frame();
    chk("lit_latest_was1", bus.o_wr_bank, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write_frame();
      chk("lit_drop_wr", bus.o_wr_bank, (i % 2 == 0) ? 2 : 0);
    end
    chk("lit_drop_rd", bus.o_rd_bank, 1);
    chk("lit_drop_cnt", bus.o_drop_cnt, STATS ? 2 : 0);
    do_reset();
    pulse(1, 0, 0, 0);
    idle(3);
    pulse(0, 1, 1, 0);
    chk("lit_same_rd", bus.o_rd_bank, 0);
    chk("lit_same_wr", bus.o_wr_bank, 2);
    chk("lit_same_drop", bus.o_drop_cnt, 0);
    idle(3);
    pulse(0, 0, 1, 0);
    chk("lit_repeat_rd", bus.o_rd_bank, 0);
    chk("lit_repeat_cnt", bus.o_repeat_cnt, STATS ? 1 : 0);
    do_reset();
    pulse(1, 0, 0, 0);
    idle(3);
    pulse(1, 0, 0, 0);
    chk("lit_abort_load", bus.o_wr_load, 1);
    chk("lit_abort_wr", bus.o_wr_bank, 0);
    idle(3);
    pulse(0, 0, 1, 0);
    chk("lit_abort_rd", bus.o_rd_bank, 1);
    chk("lit_abort_ready", bus.o_frame_ready, 0);
    chk("lit_abort_rep", bus.o_repeat_cnt, STATS ? 1 : 0);
    do_reset();
    write_frame();
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_wr", bus.o_wr_bank, 0);
    chk("lit_arst_rd", bus.o_rd_bank, 1);
    chk("lit_arst_loads", {bus.o_wr_load, bus.o_rd_load}, 0);
    chk("lit_arst_ready", bus.o_frame_ready, 0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    set_in(0, 0, 0, 0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
